cpu_prog_ctrl: RTL

Program-memory and run controller for the 4-bit CPU core. It holds a 16 x 8-bit instruction store that a host loads through a valid/ready write port. It supplies `opecode`/`imm` to the CPU from the CPU's 4-bit program address, owns the CPU reset, and gates execution with a clock enable. This provides run, pause, single-step and automatic halt on a self-jump.

---
 rtl/cpu_prog_ctrl.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/cpu_prog_ctrl.sv
// ---------------------------------------------------------------------------
// cpu_prog_ctrl
//   Program store and run controller for the 4-bit CPU core. A host loads a
//   16 x 8-bit instruction memory while the controller is idle. The CPU reads
//   opecode/imm combinationally at its program address. The controller owns
//   the CPU reset and clock enable, which gives run, pause, single-step and
//   automatic halt when the CPU executes a jump to its own address.
//
// Ports
//   clk, n_rst           clock (rising edge), async active-low reset
//   wr_valid/wr_ready    host write handshake, wr_addr/wr_data = word to store
//   start/step/stop/clear run-control commands (clear > stop > start > step)
//   cpu_addr             CPU program counter
//   cpu_opecode/cpu_imm  mem[cpu_addr] split into [7:4] / [3:0]
//   cpu_n_rst, cpu_en    registered CPU reset (active low) and clock enable
//   state                0 IDLE, 1 RUN, 2 PAUSE, 3 HALT
//   retired              cpu_en cycles since leaving IDLE, saturating
// ---------------------------------------------------------------------------
module cpu_prog_ctrl #(
    parameter int          DEPTH    = 16,
    parameter logic [3:0]  HALT_OPC = 4'hF
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [3:0]  wr_addr,
    input  logic [7:0]  wr_data,
    input  logic        start,
    input  logic        step,
    input  logic        stop,
    input  logic        clear,
    input  logic [3:0]  cpu_addr,
    output logic [3:0]  cpu_opecode,
    output logic [3:0]  cpu_imm,
    output logic        cpu_n_rst,
    output logic        cpu_en,
    output logic [1:0]  state,
    output logic [15:0] retired
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_HALT  = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic        cpu_en_q, cpu_en_d;
    logic        cpu_n_rst_q, cpu_n_rst_d;
    logic [15:0] retired_q, retired_d;
    logic        step_prev_q, step_prev_d;
    logic [7:0]  mem_q [DEPTH];
    logic [7:0]  mem_d [DEPTH];

    logic        halt_hit;
    logic        step_rise;

    // Read path: combinational so the CPU sees the word in the same cycle.
    assign cpu_opecode = mem_q[cpu_addr][7:4];
    assign cpu_imm     = mem_q[cpu_addr][3:0];

    // A self-jump is only meaningful while the CPU is actually executing it.
    assign halt_hit  = cpu_en_q && (cpu_opecode == HALT_OPC) && (cpu_imm == cpu_addr);
    // A step counts only on its rising edge, so a held step gives one pulse.
    assign step_rise = step && !step_prev_q;

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q     <= ST_IDLE;
            cpu_en_q    <= 1'b0;
            cpu_n_rst_q <= 1'b0;
            retired_q   <= '0;
            step_prev_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            cpu_en_q    <= cpu_en_d;
            cpu_n_rst_q <= cpu_n_rst_d;
            retired_q   <= retired_d;
            step_prev_q <= step_prev_d;
            mem_q       <= mem_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic; command priority clear > stop > start > step.
    // In RUN/PAUSE a halt wins over stop/start because the self-jump has
    // already been executed in this cycle.
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (stop)       state_d = ST_IDLE;
                    else if (start) state_d = ST_RUN;
                    else if (step)  state_d = ST_PAUSE;
                end
                ST_RUN: begin
                    if (halt_hit)   state_d = ST_HALT;
                    else if (stop)  state_d = ST_PAUSE;
                end
                ST_PAUSE: begin
                    if (halt_hit)   state_d = ST_HALT;
                    else if (stop)  state_d = ST_PAUSE;
                    else if (start) state_d = ST_RUN;
                end
                ST_HALT: state_d = ST_HALT;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Output logic (registered CPU controls, retire counter, write port).
    // Write handshake: a word is stored at the edge where wr_valid and
    // wr_ready are both high; wr_ready is high exactly while IDLE and does
    // not depend on wr_valid.
    // -----------------------------------------------------------------------
    always_comb begin
        wr_ready    = (state_q == ST_IDLE);
        cpu_n_rst_d = (state_d != ST_IDLE);
        // One enable pulse for a fresh step edge while staying in PAUSE.
        cpu_en_d    = (state_d == ST_RUN) ||
                      ((state_q == ST_PAUSE) && (state_d == ST_PAUSE) && step_rise && !stop);
        step_prev_d = step;

        retired_d = retired_q;
        if (clear || (state_q == ST_IDLE)) begin
            retired_d = '0;
        end else if (cpu_en_q && (retired_q != 16'hFFFF)) begin
            retired_d = retired_q + 16'd1;
        end

        mem_d = mem_q;
        if (wr_valid && wr_ready) begin
            mem_d[wr_addr] = wr_data;
        end
    end

    assign cpu_en    = cpu_en_q;
    assign cpu_n_rst = cpu_n_rst_q;
    assign state     = state_q;
    assign retired   = retired_q;

endmodule
